sprite_engine: RTL and testbench
================================

# sprite_engine

Per-pixel sprite stage that sits between the SVGA timing generator and the palette lookup. From the current pixel coordinate and a moving sprite position it generates the sprite frame-buffer (sram) read address, applies transparency to the returned palette index, and delays the sync and enable signals so that everything leaves the block aligned. Once per frame, during vertical sync, it advances the sprite position with edge bounce.

## Interface
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 600, visible height in lines
- SPRITE_W, 32, sprite width; must be a power of two
- SPRITE_H, 32, sprite height; SPRITE_W*SPRITE_H = 2^ADDR_WIDTH
- ADDR_WIDTH, 10, sprite memory address width
- DATA_WIDTH, 8, palette index width
- TRANSPARENT, 8'h00, index treated as see-through
- BG_INDEX, 8'h01, index output outside the sprite or on transparent texels
- START_X, 0, reset X position
- START_Y, 0, reset Y position
- STEP_X, 1, pixels moved per frame in X
- STEP_Y, 1, lines moved per frame in Y
- VSYNC_ACTIVE, 1, polarity of vsync_in

Ports:
- clk  in  1  pixel clock (50 MHz)
- reset  in  1  synchronous, active-high
- pixel_x  in  11  current X from timing generator
- pixel_y  in  10  current Y
- video_enable  in  1  visible-area flag
- hsync_in, vsync_in  in  1  raw syncs
- move_en  in  1  allow per-frame movement
- vram_data  in  DATA_WIDTH  sram read data; 1-cycle registered latency
- vram_addr  out  ADDR_WIDTH  sram read address
- pixel_index  out  DATA_WIDTH  palette index
- pixel_valid  out  1  delayed video_enable
- hsync_out, vsync_out  out  1  syncs delayed 3 cycles
- sprite_x  out  11, sprite_y  out  10  current top-left corner

## Operation
- Stage 1, registered:
  - hit1 = video_enable && sprite_x ≤ pixel_x < sprite_x+SPRITE_W && sprite_y ≤ pixel_y < sprite_y+SPRITE_H.
  - vram_addr = (pixel_y−sprite_y)*SPRITE_W + (pixel_x−sprite_x), computed as shift-and-concatenate, when hit1; otherwise 0.
  - Comparisons use 12-bit unsigned sums, so sprite_x+SPRITE_W never overflows.
- Stage 2: hit, enable and syncs are delayed one more cycle to align with vram_data.
- Stage 3, registered:
  - pixel_index = vram_data when hit2 && vram_data ≠ TRANSPARENT.
  - pixel_index = BG_INDEX when en2 && !(hit2 && vram_data ≠ TRANSPARENT).
  - pixel_index = 0 when !en2.
- Movement FSM states:
  - WAIT_VS: a vsync_in transition from inactive to active (edge-detected on a registered copy) goes to MOVE_X if move_en, else stays in WAIT_VS.
  - MOVE_X, one cycle:
    - If dir_x=+ and sprite_x+STEP_X ≥ SCREEN_W−SPRITE_W: sprite_x=SCREEN_W−SPRITE_W, dir_x=−.
    - If dir_x=− and sprite_x ≤ STEP_X: sprite_x=0, dir_x=+.
    - Otherwise sprite_x ± STEP_X.
    - Goes to MOVE_Y.
  - MOVE_Y: same rules with SCREEN_H and dir_y; goes to WAIT_VS.
- Position changes only inside vsync, so a visible frame is never torn.
- A second vsync edge arriving while in MOVE_X or MOVE_Y is ignored.
- move_en is sampled only at the vsync edge.

## Timing
- Latency: inputs at cycle N appear on pixel_index, pixel_valid, hsync_out and vsync_out at cycle N+3. vram_addr is valid at N+1.
- Throughput: one pixel per clock, no stalls.
- Reset values:
  - vram_addr=0, pixel_index=0, pixel_valid=0.
  - hsync_out and vsync_out = !VSYNC_ACTIVE (inactive level).
  - sprite_x=START_X, sprite_y=START_Y, dir_x=+, dir_y=+.
  - FSM=WAIT_VS; all pipeline registers cleared.
- Reset mid-frame: outputs hold their reset values for 3 cycles after reset deasserts, then track the inputs. A movement in progress is abandoned and the position returns to START.
- Boundary: a sprite touching the right edge (sprite_x=SCREEN_W−SPRITE_W) covers x=768..799 with no wrap. Pixel 800 and beyond is never a hit.
- Movement completes 2 cycles after the vsync edge.

## Test plan
- Reset for 5 cycles, then pixel (0,0), enable=1, vram_data=8'h2A -> vram_addr=0 at N+1; pixel_index=8'h2A, pixel_valid=1 at N+3.
- Sprite at (0,0), pixel (5,3) -> vram_addr=101; pixel (32,0) -> vram_addr=0, pixel_index=BG_INDEX at N+3.
- vram_data=TRANSPARENT inside the sprite -> pixel_index=8'h01. With enable=0 -> pixel_index=0, pixel_valid=0.
- move_en=1, 3 vsync pulses -> sprite_x=3, sprite_y=3. With move_en=0 the position is unchanged.
- Force sprite_x=767, dir_x=+, one vsync -> sprite_x=768, dir_x=−; next vsync -> 767. Same check on the Y axis at 568.
- Assert reset for 1 cycle mid-line -> next 3 outputs are 0 / sync inactive; position returns to (START_X, START_Y).

Source files
------------

// File: rtl/sprite_engine.sv
// sprite_engine: per-pixel sprite overlay stage between the SVGA timing
// generator and the palette lookup. Three-stage pixel pipeline plus a
// once-per-frame bouncing position update driven by vertical sync.
module sprite_engine #(
  parameter int unsigned          SCREEN_W     = 800,
  parameter int unsigned          SCREEN_H     = 600,
  parameter int unsigned          SPRITE_W     = 32,
  parameter int unsigned          SPRITE_H     = 32,
  parameter int unsigned          ADDR_WIDTH   = 10,
  parameter int unsigned          DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 8'h00,
  parameter logic [DATA_WIDTH-1:0] BG_INDEX    = 8'h01,
  parameter int unsigned          START_X      = 0,
  parameter int unsigned          START_Y      = 0,
  parameter int unsigned          STEP_X       = 1,
  parameter int unsigned          STEP_Y       = 1,
  parameter logic                 VSYNC_ACTIVE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_enable,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  move_en,
  input  logic [DATA_WIDTH-1:0] vram_data,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0] pixel_index,
  output logic                  pixel_valid,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic [10:0]           sprite_x,
  output logic [9:0]            sprite_y
);

  localparam int unsigned XBITS = $clog2(SPRITE_W);
  localparam int unsigned YBITS = $clog2(SPRITE_H);
  localparam logic [10:0] MAX_X = 11'(SCREEN_W - SPRITE_W);
  localparam logic [9:0]  MAX_Y = 10'(SCREEN_H - SPRITE_H);
  localparam logic        SYNC_IDLE = ~VSYNC_ACTIVE;

  typedef enum logic [1:0] {WAIT_VS, MOVE_X, MOVE_Y} state_t;

  state_t state, state_nx;
  logic [10:0] sprite_x_nx;
  logic [9:0]  sprite_y_nx;
  logic        dir_x, dir_x_nx, dir_y, dir_y_nx;
  logic        vs_q;

  logic             hit1, en1, hs1, vs1;
  logic             hit2, en2, hs2, vs2;
  logic [11:0]      px_w, py_w, sx_w, sy_w, sx_end, sy_end;
  logic             hit_c;
  logic [XBITS-1:0] dx_c;
  logic [YBITS-1:0] dy_c;
  logic [DATA_WIDTH-1:0] index_c;
  logic             vs_edge_c;
  logic [11:0]      x_fwd;
  logic [10:0]      y_fwd;

  // Sprite window test with 12-bit sums so the right/bottom edge cannot wrap
  always_comb begin
    px_w   = {1'b0, pixel_x};
    py_w   = {2'b00, pixel_y};
    sx_w   = {1'b0, sprite_x};
    sy_w   = {2'b00, sprite_y};
    sx_end = sx_w + 12'(SPRITE_W);
    sy_end = sy_w + 12'(SPRITE_H);
    hit_c  = video_enable && (px_w >= sx_w) && (px_w < sx_end) &&
             (py_w >= sy_w) && (py_w < sy_end);
    dx_c   = XBITS'(pixel_x) - XBITS'(sprite_x);
    dy_c   = YBITS'(pixel_y) - YBITS'(sprite_y);
  end

  // Transparency and background selection for the output stage
  always_comb begin
    index_c = '0;
    if (en2) begin
      if (hit2 && (vram_data != TRANSPARENT)) index_c = vram_data;
      else                                     index_c = BG_INDEX;
    end
  end

  // Three-stage pixel pipeline: address, memory-latency alignment, output
  always_ff @(posedge clk) begin
    if (reset) begin
      hit1        <= 1'b0;
      en1         <= 1'b0;
      hs1         <= SYNC_IDLE;
      vs1         <= SYNC_IDLE;
      vram_addr   <= '0;
      hit2        <= 1'b0;
      en2         <= 1'b0;
      hs2         <= SYNC_IDLE;
      vs2         <= SYNC_IDLE;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
      hsync_out   <= SYNC_IDLE;
      vsync_out   <= SYNC_IDLE;
    end else begin
      hit1        <= hit_c;
      en1         <= video_enable;
      hs1         <= hsync_in;
      vs1         <= vsync_in;
      vram_addr   <= hit_c ? ADDR_WIDTH'({dy_c, dx_c}) : '0;
      hit2        <= hit1;
      en2         <= en1;
      hs2         <= hs1;
      vs2         <= vs1;
      pixel_index <= index_c;
      pixel_valid <= en2;
      hsync_out   <= hs2;
      vsync_out   <= vs2;
    end
  end

  // Movement FSM state, position and direction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_VS;
      sprite_x <= 11'(START_X);
      sprite_y <= 10'(START_Y);
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      vs_q     <= SYNC_IDLE;
    end else begin
      state    <= state_nx;
      sprite_x <= sprite_x_nx;
      sprite_y <= sprite_y_nx;
      dir_x    <= dir_x_nx;
      dir_y    <= dir_y_nx;
      vs_q     <= vsync_in;
    end
  end

  // Next-state and bounce logic; one axis per cycle after the vsync edge
  always_comb begin
    state_nx    = state;
    sprite_x_nx = sprite_x;
    sprite_y_nx = sprite_y;
    dir_x_nx    = dir_x;
    dir_y_nx    = dir_y;
    vs_edge_c   = (vsync_in == VSYNC_ACTIVE) && (vs_q != VSYNC_ACTIVE);
    x_fwd       = {1'b0, sprite_x} + 12'(STEP_X);
    y_fwd       = {1'b0, sprite_y} + 11'(STEP_Y);
    case (state)
      WAIT_VS: begin
        if (vs_edge_c && move_en) state_nx = MOVE_X;
      end
      MOVE_X: begin
        if (dir_x) begin
          if (x_fwd >= {1'b0, MAX_X}) begin
            sprite_x_nx = MAX_X;
            dir_x_nx    = 1'b0;
          end else begin
            sprite_x_nx = x_fwd[10:0];
          end
        end else begin
          if (sprite_x <= 11'(STEP_X)) begin
            sprite_x_nx = '0;
            dir_x_nx    = 1'b1;
          end else begin
            sprite_x_nx = sprite_x - 11'(STEP_X);
          end
        end
        state_nx = MOVE_Y;
      end
      MOVE_Y: begin
        if (dir_y) begin
          if (y_fwd >= {1'b0, MAX_Y}) begin
            sprite_y_nx = MAX_Y;
            dir_y_nx    = 1'b0;
          end else begin
            sprite_y_nx = y_fwd[9:0];
          end
        end else begin
          if (sprite_y <= 10'(STEP_Y)) begin
            sprite_y_nx = '0;
            dir_y_nx    = 1'b1;
          end else begin
            sprite_y_nx = sprite_y - 10'(STEP_Y);
          end
        end
        state_nx = WAIT_VS;
      end
      default: state_nx = WAIT_VS;
    endcase
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed testbench for sprite_engine: pixel pipeline, transparency,
// sync delay, per-frame movement with bounce, and mid-frame reset.
module tb_sprite_engine;

  logic        clk;
  logic        reset;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        video_enable;
  logic        hsync_in;
  logic        vsync_in;
  logic        move_en;
  logic [7:0]  vram_data;
  logic [9:0]  vram_addr;
  logic [7:0]  pixel_index;
  logic        pixel_valid;
  logic        hsync_out;
  logic        vsync_out;
  logic [10:0] sprite_x;
  logic [9:0]  sprite_y;

  int n_cmp = 0;
  int n_err = 0;

  sprite_engine dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_enable(video_enable), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .move_en(move_en), .vram_data(vram_data), .vram_addr(vram_addr),
    .pixel_index(pixel_index), .pixel_valid(pixel_valid),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .sprite_x(sprite_x), .sprite_y(sprite_y)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Push one pixel through the pipeline, feeding vram_data in its memory slot
  task automatic run_pixel(input logic [10:0] x, input logic [9:0] y,
                           input logic en, input logic [7:0] data,
                           output logic [9:0] addr, output logic [7:0] idx,
                           output logic valid);
    @(negedge clk); pixel_x = x; pixel_y = y; video_enable = en;
    @(negedge clk); addr = vram_addr;
    @(negedge clk); vram_data = data;
    @(negedge clk); idx = pixel_index; valid = pixel_valid;
  endtask

  // One vsync pulse long enough for the move to complete
  task automatic vsync_pulse();
    @(negedge clk); vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    vsync_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pixel_x = '0; pixel_y = '0; video_enable = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; move_en = 1'b0; vram_data = '0;
    repeat (5) @(negedge clk);
    n_cmp++; if (vram_addr !== 10'd0) begin n_err++; $display("FAIL rst_addr got %0d want 0", vram_addr); end
    n_cmp++; if (pixel_index !== 8'h00) begin n_err++; $display("FAIL rst_index got %h want 00", pixel_index); end
    n_cmp++; if (pixel_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", pixel_valid); end
    n_cmp++; if (hsync_out !== 1'b0 || vsync_out !== 1'b0) begin n_err++; $display("FAIL rst_sync got %b%b want 00", hsync_out, vsync_out); end
    n_cmp++; if (sprite_x !== 11'd0 || sprite_y !== 10'd0) begin n_err++; $display("FAIL rst_pos got (%0d,%0d) want (0,0)", sprite_x, sprite_y); end
    reset = 1'b0;
  endtask

  task automatic test_pixel_path();
    logic [9:0] a; logic [7:0] i; logic v;
    run_pixel(11'd0, 10'd0, 1'b1, 8'h2A, a, i, v);
    n_cmp++; if (a !== 10'd0) begin n_err++; $display("FAIL p00_addr got %0d want 0", a); end
    n_cmp++; if (i !== 8'h2A || v !== 1'b1) begin n_err++; $display("FAIL p00_out got %h/%b want 2a/1", i, v); end
    run_pixel(11'd5, 10'd3, 1'b1, 8'h77, a, i, v);
    n_cmp++; if (a !== 10'd101) begin n_err++; $display("FAIL p53_addr got %0d want 101", a); end
    n_cmp++; if (i !== 8'h77 || v !== 1'b1) begin n_err++; $display("FAIL p53_out got %h/%b want 77/1", i, v); end
    run_pixel(11'd32, 10'd0, 1'b1, 8'h55, a, i, v);
    n_cmp++; if (a !== 10'd0) begin n_err++; $display("FAIL p320_addr got %0d want 0", a); end
    n_cmp++; if (i !== 8'h01 || v !== 1'b1) begin n_err++; $display("FAIL p320_out got %h/%b want 01/1", i, v); end
  endtask

  task automatic test_transparency();
    logic [9:0] a; logic [7:0] i; logic v;
    run_pixel(11'd1, 10'd1, 1'b1, 8'h00, a, i, v);
    n_cmp++; if (a !== 10'd33) begin n_err++; $display("FAIL transp_addr got %0d want 33", a); end
    n_cmp++; if (i !== 8'h01 || v !== 1'b1) begin n_err++; $display("FAIL transp_out got %h/%b want 01/1", i, v); end
    run_pixel(11'd1, 10'd1, 1'b0, 8'h2A, a, i, v);
    n_cmp++; if (a !== 10'd0) begin n_err++; $display("FAIL blank_addr got %0d want 0", a); end
    n_cmp++; if (i !== 8'h00 || v !== 1'b0) begin n_err++; $display("FAIL blank_out got %h/%b want 00/0", i, v); end
  endtask

  task automatic test_sync_delay();
    logic [1:0] exp_s;
    move_en = 1'b0;
    @(negedge clk); hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge clk); hsync_in = 1'b0; vsync_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      exp_s = (k == 3) ? 2'b11 : 2'b00;
      n_cmp++;
      if ({hsync_out, vsync_out} !== exp_s) begin
        n_err++; $display("FAIL sync_delay_%0d got %b want %b", k, {hsync_out, vsync_out}, exp_s);
      end
    end
  endtask

  task automatic test_move();
    move_en = 1'b1;
    repeat (3) vsync_pulse();
    n_cmp++; if (sprite_x !== 11'd3 || sprite_y !== 10'd3) begin n_err++; $display("FAIL move3 got (%0d,%0d) want (3,3)", sprite_x, sprite_y); end
    move_en = 1'b0;
    repeat (2) vsync_pulse();
    n_cmp++; if (sprite_x !== 11'd3 || sprite_y !== 10'd3) begin n_err++; $display("FAIL move_dis got (%0d,%0d) want (3,3)", sprite_x, sprite_y); end
  endtask

  task automatic test_back_to_back();
    move_en = 1'b1;
    @(negedge clk); vsync_in = 1'b1;
    @(negedge clk); vsync_in = 1'b0;
    @(negedge clk); vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (sprite_x !== 11'd4 || sprite_y !== 10'd4) begin n_err++; $display("FAIL double_edge got (%0d,%0d) want (4,4)", sprite_x, sprite_y); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); pixel_x = 11'd40; pixel_y = 10'd40; video_enable = 1'b1;
    hsync_in = 1'b1; vram_data = 8'h2A; move_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pixel_valid !== 1'b1 || hsync_out !== 1'b1) begin n_err++; $display("FAIL pre_rst got %b/%b want 1/1", pixel_valid, hsync_out); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_cmp++; if (sprite_x !== 11'd0 || sprite_y !== 10'd0) begin n_err++; $display("FAIL mid_rst_pos got (%0d,%0d) want (0,0)", sprite_x, sprite_y); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (pixel_index !== 8'h00 || pixel_valid !== 1'b0 || hsync_out !== 1'b0) begin
        n_err++; $display("FAIL mid_rst_hold_%0d got %h/%b/%b want 00/0/0", k, pixel_index, pixel_valid, hsync_out);
      end
    end
    @(negedge clk);
    n_cmp++; if (pixel_index !== 8'h01 || pixel_valid !== 1'b1 || hsync_out !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_track got %h/%b/%b want 01/1/1", pixel_index, pixel_valid, hsync_out);
    end
    hsync_in = 1'b0;
  endtask

  task automatic test_bounce();
    logic [9:0] a; logic [7:0] i; logic v;
    logic [10:0] ex; logic [9:0] ey;
    move_en = 1'b1;
    for (int n = 1; n <= 769; n++) begin
      vsync_pulse();
      if (n == 567 || n == 568 || n == 569 || n == 767 || n == 768 || n == 769) begin
        case (n)
          567:     begin ex = 11'd567; ey = 10'd567; end
          568:     begin ex = 11'd568; ey = 10'd568; end
          569:     begin ex = 11'd569; ey = 10'd567; end
          767:     begin ex = 11'd767; ey = 10'd369; end
          768:     begin ex = 11'd768; ey = 10'd368; end
          default: begin ex = 11'd767; ey = 10'd367; end
        endcase
        n_cmp++;
        if (sprite_x !== ex || sprite_y !== ey) begin
          n_err++; $display("FAIL bounce_%0d got (%0d,%0d) want (%0d,%0d)", n, sprite_x, sprite_y, ex, ey);
        end
      end
      if (n == 768) begin
        run_pixel(11'd799, 10'd368, 1'b1, 8'h55, a, i, v);
        n_cmp++; if (a !== 10'd31 || i !== 8'h55) begin n_err++; $display("FAIL edge799 got %0d/%h want 31/55", a, i); end
        run_pixel(11'd800, 10'd368, 1'b1, 8'h55, a, i, v);
        n_cmp++; if (a !== 10'd0 || i !== 8'h01) begin n_err++; $display("FAIL edge800 got %0d/%h want 0/01", a, i); end
        run_pixel(11'd768, 10'd399, 1'b1, 8'h66, a, i, v);
        n_cmp++; if (a !== 10'd992 || i !== 8'h66) begin n_err++; $display("FAIL corner got %0d/%h want 992/66", a, i); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixel_path();
    test_transparency();
    test_sync_delay();
    test_move();
    test_back_to_back();
    test_reset_mid();
    test_bounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
